// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns PC/IR, sequences opcode+address byte fetches,
// hands instructions to execute, and applies jumps and halt.
module fetch_ctrl #(
  parameter int               ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [3:0]       HLT_OPCODE = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready,
  input  logic              exec_done,
  input  logic              jump_en,
  output logic [ADDR_W-1:0] pc_addr,
  output logic [ADDR_W-1:0] ir_addr,
  output logic [3:0]        ir_op,
  output logic              addr_sel,
  output logic              mem_rd,
  output logic              exec_start,
  output logic              halted
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH_OP  = 3'd1,
    FETCH_ARG = 3'd2,
    EXEC      = 3'd3,
    HALT      = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ir_addr_q, ir_addr_d;
  logic [3:0]        ir_op_q, ir_op_d;
  logic              exec_start_q, exec_start_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      ir_addr_q    <= '0;
      ir_op_q      <= '0;
      exec_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_addr_q    <= ir_addr_d;
      ir_op_q      <= ir_op_d;
      exec_start_q <= exec_start_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_addr_d    = ir_addr_q;
    ir_op_d      = ir_op_q;
    exec_start_d = 1'b0;
    unique case (state_q)
      IDLE: if (run) state_d = FETCH_OP;
      FETCH_OP: if (mem_ready) begin
        ir_op_d = mem_rdata[7:4];
        pc_d    = pc_q + ADDR_W'(1);
        state_d = FETCH_ARG;
      end
      FETCH_ARG: if (mem_ready) begin
        // Halt still consumes its address byte, so PC ends at halt address + 2.
        ir_addr_d = ADDR_W'(mem_rdata);
        pc_d      = pc_q + ADDR_W'(1);
        if (ir_op_q == HLT_OPCODE) begin
          state_d = HALT;
        end else begin
          state_d      = EXEC;
          exec_start_d = 1'b1;
        end
      end
      EXEC: if (exec_done) begin
        if (jump_en) pc_d = ir_addr_q;
        state_d = run ? FETCH_OP : IDLE;
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  assign pc_addr    = pc_q;
  assign ir_addr    = ir_addr_q;
  assign ir_op      = ir_op_q;
  assign exec_start = exec_start_q;
  assign addr_sel   = (state_q == EXEC);
  assign mem_rd     = (state_q == FETCH_OP) || (state_q == FETCH_ARG);
  assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed table-driven bench for fetch_ctrl plus hand sequences for
// run-drop mid-fetch and asynchronous reset during execute.
module tb_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, run, mem_ready, exec_done, jump_en;
  logic [7:0] mem_rdata;
  logic [7:0] pc_addr, ir_addr;
  logic [3:0] ir_op;
  logic       addr_sel, mem_rd, exec_start, halted;

  int tot = 0;
  int errs = 0;

  fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .run(run), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .exec_done(exec_done), .jump_en(jump_en),
    .pc_addr(pc_addr), .ir_addr(ir_addr), .ir_op(ir_op),
    .addr_sel(addr_sel), .mem_rd(mem_rd), .exec_start(exec_start),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       run;
    logic [7:0] rdata;
    logic       rdy, done, jmp;
    logic [7:0] pc, ira;
    logic [3:0] op;
    logic       sel, rd, es, hlt;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input logic r, input logic [7:0] d, input logic rdy, input logic dn,
                      input logic j, input logic [7:0] pc, input logic [7:0] ira,
                      input logic [3:0] op, input logic sel, input logic rd,
                      input logic es, input logic hlt);
    vec_t t;
    t.run = r; t.rdata = d; t.rdy = rdy; t.done = dn; t.jmp = j;
    t.pc = pc; t.ira = ira; t.op = op; t.sel = sel; t.rd = rd; t.es = es; t.hlt = hlt;
    vq.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] pc, input logic [7:0] ira,
                         input logic [3:0] op, input logic sel, input logic rd,
                         input logic es, input logic hlt);
    chk({tag, ".pc"}, 32'(pc_addr), 32'(pc));
    chk({tag, ".ir_addr"}, 32'(ir_addr), 32'(ira));
    chk({tag, ".ir_op"}, 32'(ir_op), 32'(op));
    chk({tag, ".addr_sel"}, 32'(addr_sel), 32'(sel));
    chk({tag, ".mem_rd"}, 32'(mem_rd), 32'(rd));
    chk({tag, ".exec_start"}, 32'(exec_start), 32'(es));
    chk({tag, ".halted"}, 32'(halted), 32'(hlt));
  endtask

  task automatic step(input logic r, input logic [7:0] d, input logic rdy,
                      input logic dn, input logic j);
    run = r; mem_rdata = d; mem_ready = rdy; exec_done = dn; jump_en = j;
    @(posedge clk); #1;
  endtask

  initial begin
    //    run rdata  rdy dn j   pc     ira    op  sel rd es h
    addv(0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 4'h0, 0, 0, 0, 0); // idle x3
    addv(0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 4'h0, 0, 0, 0, 0);
    addv(0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 4'h0, 0, 0, 0, 0);
    addv(1, 8'h00, 0, 0, 0, 8'h00, 8'h00, 4'h0, 0, 1, 0, 0); // -> FETCH_OP
    addv(1, 8'h35, 1, 0, 0, 8'h01, 8'h00, 4'h3, 0, 1, 0, 0); // opcode 3
    addv(1, 8'h42, 1, 0, 0, 8'h02, 8'h42, 4'h3, 1, 0, 1, 0); // arg 42 -> EXEC
    addv(1, 8'h00, 0, 0, 0, 8'h02, 8'h42, 4'h3, 1, 0, 0, 0);
    addv(1, 8'h00, 0, 1, 0, 8'h02, 8'h42, 4'h3, 0, 1, 0, 0); // done -> FETCH_OP
    addv(1, 8'h77, 0, 0, 0, 8'h02, 8'h42, 4'h3, 0, 1, 0, 0); // wait states
    addv(1, 8'h77, 0, 0, 0, 8'h02, 8'h42, 4'h3, 0, 1, 0, 0);
    addv(1, 8'h77, 0, 0, 0, 8'h02, 8'h42, 4'h3, 0, 1, 0, 0);
    addv(1, 8'h77, 0, 0, 0, 8'h02, 8'h42, 4'h3, 0, 1, 0, 0);
    addv(1, 8'h51, 1, 0, 0, 8'h03, 8'h42, 4'h5, 0, 1, 0, 0);
    addv(1, 8'h88, 0, 0, 0, 8'h03, 8'h42, 4'h5, 0, 1, 0, 0); // arg wait
    addv(1, 8'h10, 1, 0, 0, 8'h04, 8'h10, 4'h5, 1, 0, 1, 0);
    addv(1, 8'h00, 0, 1, 1, 8'h10, 8'h10, 4'h5, 0, 1, 0, 0); // jump to 10
    addv(1, 8'h62, 1, 0, 0, 8'h11, 8'h10, 4'h6, 0, 1, 0, 0);
    addv(1, 8'hA0, 1, 0, 0, 8'h12, 8'hA0, 4'h6, 1, 0, 1, 0);
    addv(1, 8'h00, 0, 0, 1, 8'h12, 8'hA0, 4'h6, 1, 0, 0, 0); // jump_en alone
    addv(1, 8'h00, 0, 1, 1, 8'hA0, 8'hA0, 4'h6, 0, 1, 0, 0); // jump to A0
    addv(1, 8'h70, 1, 0, 0, 8'hA1, 8'hA0, 4'h7, 0, 1, 0, 0);
    addv(1, 8'hFE, 1, 0, 0, 8'hA2, 8'hFE, 4'h7, 1, 0, 1, 0);
    addv(0, 8'h00, 0, 1, 1, 8'hFE, 8'hFE, 4'h7, 0, 0, 0, 0); // 1-cycle EXEC -> IDLE
    addv(0, 8'h55, 1, 1, 1, 8'hFE, 8'hFE, 4'h7, 0, 0, 0, 0); // ignored in IDLE
    addv(1, 8'h00, 0, 0, 0, 8'hFE, 8'hFE, 4'h7, 0, 1, 0, 0);
    addv(1, 8'hF3, 1, 0, 0, 8'hFF, 8'hFE, 4'hF, 0, 1, 0, 0); // halt opcode
    addv(1, 8'h99, 1, 0, 0, 8'h00, 8'h99, 4'hF, 0, 0, 0, 1); // wrap, HALT
    addv(1, 8'h21, 1, 1, 1, 8'h00, 8'h99, 4'hF, 0, 0, 0, 1); // stuck in HALT
    addv(1, 8'h21, 1, 1, 0, 8'h00, 8'h99, 4'hF, 0, 0, 0, 1);

    run = 0; mem_rdata = 0; mem_ready = 0; exec_done = 0; jump_en = 0;
    rst_n = 0;
    #12;
    chk_all("reset", 8'h00, 8'h00, 4'h0, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1;

    foreach (vq[i]) begin
      step(vq[i].run, vq[i].rdata, vq[i].rdy, vq[i].done, vq[i].jmp);
      chk_all($sformatf("vec%0d", i), vq[i].pc, vq[i].ira, vq[i].op,
              vq[i].sel, vq[i].rd, vq[i].es, vq[i].hlt);
    end

    // Only reset leaves HALT; run dropped mid-fetch still completes the instruction.
    rst_n = 0; #1;
    chk_all("rst_from_halt", 8'h00, 8'h00, 4'h0, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1;
    step(1, 8'h00, 0, 0, 0);
    chk_all("seq.fetch", 8'h00, 8'h00, 4'h0, 0, 1, 0, 0);
    step(0, 8'h12, 1, 0, 0);
    chk_all("seq.op_norun", 8'h01, 8'h00, 4'h1, 0, 1, 0, 0);
    step(0, 8'h34, 1, 0, 0);
    chk_all("seq.exec", 8'h02, 8'h34, 4'h1, 1, 0, 1, 0);

    // Asynchronous reset between edges while in EXEC.
    #3;
    chk("pre_rst.addr_sel", 32'(addr_sel), 32'd1);
    rst_n = 0; #1;
    chk_all("async_rst", 8'h00, 8'h00, 4'h0, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1;
    step(0, 8'h00, 1, 1, 1);
    chk_all("post_rst_idle", 8'h00, 8'h00, 4'h0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", tot, errs);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch controller for the 8-bit CPU. It sits directly upstream of the address multiplexer and drives its PC address, IR address and select inputs.
- Holds the program counter and instruction register. Sequences two-byte fetches (opcode byte, then address byte), hands each instruction to the execute stage, and applies jumps and halt.

Parameters:
- ADDR_W, 8, width of program counter and instruction address field.
- RESET_PC, 8'h00, PC value loaded on reset.
- HLT_OPCODE, 4'hF, opcode (instruction byte [7:4]) that halts the core.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset. Asynchronous, active-low.
- run  input  1  level enable; starts fetching from IDLE.
- mem_rdata  input  8  memory read data for the current address.
- mem_ready  input  1  mem_rdata is valid this cycle.
- exec_done  input  1  execute stage has finished the current instruction.
- jump_en  input  1  qualifies exec_done: load PC from ir_addr.
- pc_addr  output  ADDR_W  program counter, feeds the mux PC input.
- ir_addr  output  ADDR_W  instruction address byte, feeds the mux IR input.
- ir_op  output  4  latched opcode.
- addr_sel  output  1  mux select: 1 = ir_addr, 0 = pc_addr.
- mem_rd  output  1  memory read request.
- exec_start  output  1  one-cycle pulse at the start of execution.
- halted  output  1  core halted.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, pc_addr=RESET_PC, ir_addr=0, ir_op=0, addr_sel=0, mem_rd=0, exec_start=0, halted=0. Takes effect immediately from any state. Any in-flight fetch or execute is abandoned.
- All state transitions happen on the rising clk edge.
- addr_sel, mem_rd and halted are Moore outputs decoded from the state register only.
- exec_start is registered: 1 only in the first EXEC cycle.
- States:
  - IDLE: addr_sel=0, mem_rd=0. If run=1, go to FETCH_OP; otherwise stay.
  - FETCH_OP: addr_sel=0, mem_rd=1. If mem_ready=0, hold with all registers unchanged. If mem_ready=1: ir_op<=mem_rdata[7:4]; pc<=pc+1; go to FETCH_ARG.
  - FETCH_ARG: addr_sel=0, mem_rd=1. If mem_ready=0, hold. If mem_ready=1: ir_addr<=mem_rdata; pc<=pc+1.
    - If ir_op==HLT_OPCODE, go to HALT.
    - Otherwise go to EXEC and set exec_start=1 for the next cycle.
  - EXEC: addr_sel=1, mem_rd=0 (execute stage owns memory). Wait for exec_done.
    - On exec_done=1: if jump_en=1, pc<=ir_addr; otherwise pc is unchanged.
    - Then go to FETCH_OP if run=1, else IDLE.
    - exec_done on the same cycle as exec_start is legal: a one-cycle EXEC.
  - HALT: halted=1, addr_sel=0, mem_rd=0. Only reset leaves this state.
- PC arithmetic: modulo 2^ADDR_W. 8'hFF+1 = 8'h00, with no flag.
- The halt instruction still consumes its address byte. PC after halt = halt address + 2.
- run is sampled only in IDLE and on the exec_done cycle. Deasserting run mid-fetch lets the current instruction complete.
- mem_ready outside the FETCH states is ignored. exec_done and jump_en outside EXEC are ignored.
- jump_en without exec_done has no effect.
- ir_op and ir_addr hold their values until overwritten by the next fetch.

Test Plan:
- Reset and start: rst_n=0, then release with run=0 for 3 cycles -> pc_addr=00, addr_sel=0, mem_rd=0, state IDLE. Set run=1 -> mem_rd=1 on the next cycle.
- Sequential fetch: memory [00]=8'h3x, [01]=8'h42, mem_ready always 1 -> ir_op=3, ir_addr=42, pc_addr=02. exec_start pulses once with addr_sel=1. exec_done one cycle later -> back to FETCH_OP at pc 02.
- Wait states: mem_ready low for 4 cycles in FETCH_OP -> pc_addr, ir_op and mem_rd=1 all held; latch occurs on the cycle mem_ready=1.
- Jump: instruction at 10 with address byte 8'hA0; exec_done=1 with jump_en=1 -> pc_addr=A0 and the next opcode fetch targets A0.
- Wrap and halt: PC=FE holding opcode F -> halted=1, pc_addr=00, mem_rd=0. Further run or mem_ready has no effect until reset.
- Async reset mid-EXEC: drop rst_n between clock edges while addr_sel=1 -> all outputs return to reset values immediately, without waiting for a clock edge.
